// File: rtl/dice_counter_if.sv
// Round-input and score-output bundle for dice_counter.
// With DICE_FACE_CHECK_EN defined the bundle also carries face_err.
interface dice_counter_if #(
    parameter int unsigned TALLY_W = 8
);
    logic               in_valid;
    logic               clear;
    logic [0:2]         a;
    logic [0:2]         b;
    logic [0:2]         c;
    logic [0:2]         d;
    logic [0:3]         sum1;
    logic [0:3]         sum2;
    logic [0:2]         x;
    logic               out_valid;
    logic [TALLY_W-1:0] wins;
    logic [TALLY_W-1:0] ties;
    logic [TALLY_W-1:0] losses;
`ifdef DICE_FACE_CHECK_EN
    logic               face_err;
`endif

    modport master (
        output in_valid, clear, a, b, c, d,
        input  sum1, sum2, x, out_valid, wins, ties, losses
`ifdef DICE_FACE_CHECK_EN
        , input face_err
`endif
    );

    modport slave (
        input  in_valid, clear, a, b, c, d,
        output sum1, sum2, x, out_valid, wins, ties, losses
`ifdef DICE_FACE_CHECK_EN
        , output face_err
`endif
    );
endinterface

// File: rtl/dice_counter.sv
// Dual-dice score comparator with saturating win/tie/loss tallies.
// Optional DICE_FACE_CHECK_EN flags rounds holding a 0 or 7 and keeps them out of the tallies.
module dice_counter #(
    parameter int unsigned TALLY_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    dice_counter_if.slave bus
);
    logic [0:3]         sum1_q, sum1_d, sum1_new;
    logic [0:3]         sum2_q, sum2_d, sum2_new;
    logic [0:2]         x_q, x_d, x_new;
    logic               out_valid_q;
    logic [TALLY_W-1:0] wins_q, wins_d;
    logic [TALLY_W-1:0] ties_q, ties_d;
    logic [TALLY_W-1:0] losses_q, losses_d;
    logic               face_bad;
    logic               count_en;

    always_comb begin
        sum1_new = {1'b0, bus.a} + {1'b0, bus.b};
        sum2_new = {1'b0, bus.c} + {1'b0, bus.d};
        x_new    = {sum1_new > sum2_new, sum1_new == sum2_new, sum1_new < sum2_new};
`ifdef DICE_FACE_CHECK_EN
        face_bad = (bus.a == 3'd0) || (bus.a == 3'd7) || (bus.b == 3'd0) || (bus.b == 3'd7) ||
                   (bus.c == 3'd0) || (bus.c == 3'd7) || (bus.d == 3'd0) || (bus.d == 3'd7);
`else
        face_bad = 1'b0;
`endif
        count_en = bus.in_valid && !face_bad;

        sum1_d   = sum1_q;
        sum2_d   = sum2_q;
        x_d      = x_q;
        wins_d   = wins_q;
        ties_d   = ties_q;
        losses_d = losses_q;

        if (bus.in_valid) begin
            sum1_d = sum1_new;
            sum2_d = sum2_new;
            x_d    = x_new;
        end

        // clear takes priority over a same-cycle round for the tallies only
        if (bus.clear) begin
            wins_d   = '0;
            ties_d   = '0;
            losses_d = '0;
        end else if (count_en) begin
            if (x_new[0] && (wins_q != '1))   wins_d   = wins_q + TALLY_W'(1);
            if (x_new[1] && (ties_q != '1))   ties_d   = ties_q + TALLY_W'(1);
            if (x_new[2] && (losses_q != '1)) losses_d = losses_q + TALLY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum1_q      <= '0;
            sum2_q      <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            wins_q      <= '0;
            ties_q      <= '0;
            losses_q    <= '0;
        end else begin
            sum1_q      <= sum1_d;
            sum2_q      <= sum2_d;
            x_q         <= x_d;
            out_valid_q <= bus.in_valid;
            wins_q      <= wins_d;
            ties_q      <= ties_d;
            losses_q    <= losses_d;
        end
    end

`ifdef DICE_FACE_CHECK_EN
    logic face_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            face_err_q <= 1'b0;
        end else if (bus.in_valid) begin
            face_err_q <= face_bad;
        end
    end

    assign bus.face_err = face_err_q;
`endif

    assign bus.sum1      = sum1_q;
    assign bus.sum2      = sum2_q;
    assign bus.x         = x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wins      = wins_q;
    assign bus.ties      = ties_q;
    assign bus.losses    = losses_q;
endmodule

// File: tb/tb_dice_counter.sv
// Directed self-checking bench for dice_counter: main 8-bit instance plus a 2-bit instance
// for tally saturation. Define DICE_FACE_CHECK_EN to also exercise face_err.
module tb_dice_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dice_counter_if #(.TALLY_W(8)) bus ();
    dice_counter_if #(.TALLY_W(2)) sbus ();

    dice_counter #(.TALLY_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dice_counter #(.TALLY_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    task automatic drive(input logic [2:0] va, vb, vc, vd, input logic v, clr);
        @(negedge clk);
        bus.a        = va;
        bus.b        = vb;
        bus.c        = vc;
        bus.d        = vd;
        bus.in_valid = v;
        bus.clear    = clr;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.d         = '0;
        sbus.in_valid = 1'b0;
        sbus.clear    = 1'b0;
        sbus.a        = '0;
        sbus.b        = '0;
        sbus.c        = '0;
        sbus.d        = '0;
        rst_n         = 1'b0;
        #12;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !== '0) begin
            failures++;
            $display("FAIL reset_initial got=%h want=0",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses});
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Load a round, then reset mid-cycle: outputs must clear without a clock edge
        drive(3'd6, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.wins} !== {4'd11, 8'd1}) begin
            failures++;
            $display("FAIL reset_preload got=%h want=%h", {bus.sum1, bus.wins}, {4'd11, 8'd1});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses});
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_win();
        drive(3'd6, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid} !== {4'd11, 4'd10, 3'b100, 1'b1}) begin
            failures++;
            $display("FAIL win_round got=%h want=%h", {bus.sum1, bus.sum2, bus.x, bus.out_valid},
                     {4'd11, 4'd10, 3'b100, 1'b1});
        end
        checks++;
        if ({bus.wins, bus.ties, bus.losses} !== {8'd1, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL win_tally got=%h want=%h", {bus.wins, bus.ties, bus.losses},
                     {8'd1, 8'd0, 8'd0});
        end
    endtask

    task automatic test_tie_loss();
        drive(3'd3, 3'd4, 3'd2, 3'd5, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !==
            {4'd7, 4'd7, 3'b010, 1'b1, 8'd1, 8'd1, 8'd0}) begin
            failures++;
            $display("FAIL tie_round got=%h want=%h",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses},
                     {4'd7, 4'd7, 3'b010, 1'b1, 8'd1, 8'd1, 8'd0});
        end
        // back-to-back: no idle cycle between rounds
        drive(3'd1, 3'd1, 3'd6, 3'd6, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !==
            {4'd2, 4'd12, 3'b001, 1'b1, 8'd1, 8'd1, 8'd1}) begin
            failures++;
            $display("FAIL loss_round got=%h want=%h",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses},
                     {4'd2, 4'd12, 3'b001, 1'b1, 8'd1, 8'd1, 8'd1});
        end
    endtask

    task automatic test_hold_clear();
        drive(3'd7, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !==
                {4'd2, 4'd12, 3'b001, 1'b0, 8'd1, 8'd1, 8'd1}) begin
                failures++;
                $display("FAIL hold_%0d got=%h want=%h", i,
                         {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses},
                         {4'd2, 4'd12, 3'b001, 1'b0, 8'd1, 8'd1, 8'd1});
            end
        end
        drive(3'd6, 3'd6, 3'd1, 3'd1, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses} !==
            {4'd12, 4'd2, 3'b100, 1'b1, 8'd0, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL clear_with_round got=%h want=%h",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.wins, bus.ties, bus.losses},
                     {4'd12, 4'd2, 3'b100, 1'b1, 8'd0, 8'd0, 8'd0});
        end
        drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_out_valid_drop got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_wins;
        @(negedge clk);
        sbus.a        = 3'd6;
        sbus.b        = 3'd6;
        sbus.c        = 3'd1;
        sbus.d        = 3'd1;
        sbus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_wins = (i >= 2) ? 2'd3 : 2'(i + 1);
            @(posedge clk); #1;
            checks++;
            if ({sbus.x, sbus.wins, sbus.ties, sbus.losses} !== {3'b100, exp_wins, 2'd0, 2'd0}) begin
                failures++;
                $display("FAIL sat_round_%0d got=%h want=%h", i,
                         {sbus.x, sbus.wins, sbus.ties, sbus.losses},
                         {3'b100, exp_wins, 2'd0, 2'd0});
            end
        end
        @(negedge clk);
        sbus.in_valid = 1'b0;
    endtask

`ifdef DICE_FACE_CHECK_EN
    task automatic test_face_check();
        drive(3'd7, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.face_err, bus.wins} !==
            {4'd7, 4'd2, 3'b100, 1'b1, 1'b1, 8'd0}) begin
            failures++;
            $display("FAIL face_bad_round got=%h want=%h",
                     {bus.sum1, bus.sum2, bus.x, bus.out_valid, bus.face_err, bus.wins},
                     {4'd7, 4'd2, 3'b100, 1'b1, 1'b1, 8'd0});
        end
        drive(3'd6, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({bus.face_err, bus.wins} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL face_good_round got=%h want=%h", {bus.face_err, bus.wins},
                     {1'b0, 8'd1});
        end
        drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_win();
        test_tie_loss();
        test_hold_clear();
        test_saturation();
`ifdef DICE_FACE_CHECK_EN
        test_face_check();
`endif
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dice_counter.md
Name: dice_counter

Overview:
- Dual-dice score comparator. Adds two user-side dice values (LED chaser user/random) into sum1 and two random dice values into sum2.
- Flags sum1 >, =, or < sum2 and keeps running win/tie/loss tallies.
- Sits between the dice/LED-chaser value generators and the display/scoreboard logic.

Parameters:
- TALLY_W, 8, width of each win/tie/loss tally counter (saturating).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a/b/c/d for one round; sampled on rising clk edge
- clear  input  1  synchronous clear of tallies only
- a  input  3  led_chaser_user value, declared [0:2], a[0] = MSB
- b  input  3  led_chaser_random value, declared [0:2], b[0] = MSB
- c  input  3  random_number_1 value, declared [0:2], c[0] = MSB
- d  input  3  random_number_2 value, declared [0:2], d[0] = MSB
- sum1  output  4  registered a+b, declared [0:3], sum1[0] = MSB
- sum2  output  4  registered c+d, declared [0:3], sum2[0] = MSB
- x  output  3  registered compare one-hot, declared [0:2]: x[0]=sum1>sum2, x[1]=sum1==sum2, x[2]=sum1<sum2
- out_valid  output  1  high one cycle after an accepted in_valid
- wins  output  TALLY_W  count of rounds with x[0]
- ties  output  TALLY_W  count of rounds with x[1]
- losses  output  TALLY_W  count of rounds with x[2]

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: sum1=0, sum2=0, x=3'b000, out_valid=0, wins/ties/losses=0.
- Arithmetic: sums are unsigned 3+3 bits zero-extended to 4 bits. Maximum is 7+7=14, so no overflow.
- Compare: unsigned compare of the two 4-bit sums. Exactly one bit of x is set whenever out_valid=1.
- Latency: 1 cycle. On a rising edge with in_valid=1, sum1, sum2 and x load the new round, and out_valid=1 for that cycle.
- When in_valid=0: sum1, sum2 and x hold their last values, and out_valid=0.
- Tallies: update on the same edge that loads x. The tally matching the new x bit increments by 1 and saturates at 2^TALLY_W-1 (no wrap).
- clear: when high, all tallies go to 0 on that edge. If clear and in_valid are high together, clear wins for the tallies, while sum1/sum2/x/out_valid still load normally.
- Reset mid-round: an in-flight round is discarded and all outputs return to their reset values immediately.
- Inputs are treated as full 3-bit unsigned values. 0 and 7 are accepted unless the optional feature below is enabled.

Optional Feature:
- Macro: DICE_FACE_CHECK_EN.
- Defined:
  - Adds output port face_err (1 bit, reset 0).
  - On an accepted round, face_err registers 1 if any of a/b/c/d is 0 or 7 (not a legal die face 1..6), else 0.
  - A round with face_err=1 still updates sum1, sum2, x and out_valid, but does not change any tally.
- Undefined: no face_err port, and every accepted round updates the tallies.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> all outputs become 0 without waiting for a clock edge.
- Nominal win: a=6, b=5, c=5, d=5, in_valid=1 -> next cycle sum1=11, sum2=10, x=100, out_valid=1, wins=1.
- Tie then loss:
  - a=3, b=4, c=2, d=5 -> sum1=7, sum2=7, x=010, ties=1.
  - Then a=1, b=1, c=6, d=6 -> sum1=2, sum2=12, x=001, losses=1.
- Hold and clear:
  - in_valid=0 for 3 cycles -> outputs hold and out_valid=0.
  - clear=1 together with in_valid=1 (a=6, b=6, c=1, d=1) -> tallies=0, sum1=12, sum2=2, x=100.
- Saturation: TALLY_W=2, 5 winning rounds -> wins stays at 3.
- DICE_FACE_CHECK_EN defined: a=7, b=0, c=1, d=1 -> sum1=7, sum2=2, x=100, face_err=1, wins unchanged.
